latch_q_sync_filter: RTL and testbench
======================================

// Module: latch_q_sync_filter
// PURPOSE
//  Downstream consumer of the gated D-latch output (Q). Brings the asynchronous
//  latch output into the CLK domain through a synchronizer chain and a
//  stability filter. Emits single-cycle RISE/FALL pulses on each filtered
//  transition and keeps a saturating transition counter. Sits between the latch
//  bank and synchronous control logic.
// PARAMETERS
//  SYNC_STAGES  2  flip-flops in the synchronizer chain (>=2)
//  FILT_CYCLES  4  consecutive cycles Q_SYNC must differ from Q_FILT before Q_FILT follows (>=2)
//  CNT_W        8  width of TOGGLE_CNT
// PORTS
//  CLK         in   1      clock, all state updates on rising edge
//  RST         in   1      synchronous, active-high reset
//  Q_IN        in   1      latch output, asynchronous to CLK
//  EN          in   1      1 = filter FSM active, 0 = hold filtered state
//  CLR_CNT     in   1      synchronous clear of TOGGLE_CNT
//  Q_SYNC      out  1      last synchronizer stage (raw, unfiltered)
//  Q_FILT      out  1      filtered, registered level
//  RISE        out  1      one-cycle pulse when Q_FILT goes 0->1
//  FALL        out  1      one-cycle pulse when Q_FILT goes 1->0
//  TOGGLE_CNT  out  CNT_W  saturating count of RISE+FALL pulses
//  CNT_SAT     out  1      TOGGLE_CNT == all ones
// BEHAVIOUR
//  Reset (RST=1 at an edge): all sync stages, Q_SYNC, Q_FILT, RISE, FALL,
//   TOGGLE_CNT and CNT_SAT = 0; FSM = S_LOW; filter count = 0. RST overrides all inputs.
//  Synchronizer: shift chain, stage0 <= Q_IN every edge, independent of EN.
//   Q_SYNC = last stage. Q_SYNC reflects Q_IN SYNC_STAGES edges after capture.
//  FSM states: S_LOW, S_RISE_PEND, S_HIGH, S_FALL_PEND. Q_FILT = 1 in S_HIGH/S_FALL_PEND.
//   S_LOW:       Q_SYNC=1 -> S_RISE_PEND, fcnt=1.
//   S_RISE_PEND: Q_SYNC=0 -> S_LOW, fcnt=0 (glitch rejected, no pulse).
//                fcnt==FILT_CYCLES-1 -> S_HIGH, Q_FILT<=1, RISE<=1, fcnt=0.
//                else fcnt++.
//   S_HIGH / S_FALL_PEND: mirror image with Q_SYNC=0, FALL pulse.
//  Latency: Q_FILT changes SYNC_STAGES+FILT_CYCLES-1 edges after the edge that
//   captured the new Q_IN into stage0. Defaults: 5 edges.
//  RISE/FALL: high for exactly one cycle, registered together with Q_FILT.
//   Never both high in the same cycle.
//  EN=0: the synchronizer keeps running. A pending state returns to its stable
//   state (S_RISE_PEND->S_LOW, S_FALL_PEND->S_HIGH), fcnt=0, no pulses, Q_FILT held.
//   EN=1 resumes from the stable state with a fresh count.
//  TOGGLE_CNT: +1 on the edge after any RISE/FALL pulse is registered (samples
//   RISE|FALL). Saturates at 2^CNT_W-1 with no wrap. CNT_SAT is combinational from
//   TOGGLE_CNT. CLR_CNT=1 sets 0 and wins over a coincident increment.
//   CLR_CNT does not affect the FSM or the pulses.
//  Reset with a pending transition: discarded; after release, a Q_IN still
//   high produces a normal RISE after the full latency.
// TESTING (defaults unless stated)
//  1 RST for 3 cycles with Q_IN=1; release at edge 0 -> outputs 0 during reset;
//    Q_SYNC=1 after edge 2; Q_FILT=1 and RISE=1 after edge 5; TOGGLE_CNT=1 after edge 6.
//  2 From S_LOW, Q_IN high for 3 cycles then low -> Q_FILT stays 0, no RISE,
//    TOGGLE_CNT unchanged.
//  3 Q_IN toggles 5 times, 10 cycles per level -> RISE,FALL,RISE,FALL,RISE,
//    each 1 cycle wide, 5-edge latency; TOGGLE_CNT=5.
//  4 CNT_W=3, 9 clean transitions -> TOGGLE_CNT=7, CNT_SAT=1; CLR_CNT pulse -> 0, CNT_SAT=0.
//  5 CLR_CNT asserted on the cycle RISE is high -> TOGGLE_CNT=0 next edge; RISE
//    and Q_FILT unaffected.
//  6 EN=0 during S_RISE_PEND (fcnt=2) -> S_LOW, no RISE; EN=1 with Q_IN still
//    high -> RISE exactly FILT_CYCLES edges later. RST mid-pending -> all outputs 0 next edge.

Source files
------------

// File: rtl/latch_q_sync_filter.sv
// Synchronizes an asynchronous latch output into clk, debounces it with a
// stability filter, and reports filtered edges as pulses plus a saturating count.
module latch_q_sync_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYCLES = 4,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             q_in,
    input  logic             en,
    input  logic             clr_cnt,
    output logic             q_sync,
    output logic             q_filt,
    output logic             rise,
    output logic             fall,
    output logic [CNT_W-1:0] toggle_cnt,
    output logic             cnt_sat
);

    localparam int FCW = $clog2(FILT_CYCLES + 1);
    localparam logic [FCW-1:0] FCNT_LAST = FCW'(FILT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_LOW       = 2'd0,
        S_RISE_PEND = 2'd1,
        S_HIGH      = 2'd2,
        S_FALL_PEND = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_in;
    state_t                 state, state_d;
    logic [FCW-1:0]         fcnt, fcnt_d;
    logic                   rise_d, fall_d;

    // The filter taps the chain directly; q_sync is a registered view of the
    // chain output so it does not add a cycle to the filter's latency.
    assign sync_in = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            q_sync <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], q_in};
            q_sync <= sync_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_LOW;
            fcnt   <= '0;
            q_filt <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            state  <= state_d;
            fcnt   <= fcnt_d;
            q_filt <= (state_d == S_HIGH) || (state_d == S_FALL_PEND);
            rise   <= rise_d;
            fall   <= fall_d;
        end
    end

    always_comb begin
        state_d = state;
        fcnt_d  = fcnt;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (!en) begin
            // Disabled: abandon any pending transition, keep the filtered level.
            fcnt_d = '0;
            if (state == S_RISE_PEND) state_d = S_LOW;
            if (state == S_FALL_PEND) state_d = S_HIGH;
        end else begin
            case (state)
                S_LOW: begin
                    if (sync_in) begin
                        state_d = S_RISE_PEND;
                        fcnt_d  = FCW'(1);
                    end
                end
                S_RISE_PEND: begin
                    if (!sync_in) begin
                        state_d = S_LOW;
                        fcnt_d  = '0;
                    end else if (fcnt == FCNT_LAST) begin
                        state_d = S_HIGH;
                        fcnt_d  = '0;
                        rise_d  = 1'b1;
                    end else begin
                        fcnt_d = fcnt + FCW'(1);
                    end
                end
                S_HIGH: begin
                    if (!sync_in) begin
                        state_d = S_FALL_PEND;
                        fcnt_d  = FCW'(1);
                    end
                end
                S_FALL_PEND: begin
                    if (sync_in) begin
                        state_d = S_HIGH;
                        fcnt_d  = '0;
                    end else if (fcnt == FCNT_LAST) begin
                        state_d = S_LOW;
                        fcnt_d  = '0;
                        fall_d  = 1'b1;
                    end else begin
                        fcnt_d = fcnt + FCW'(1);
                    end
                end
                default: begin
                    state_d = S_LOW;
                    fcnt_d  = '0;
                end
            endcase
        end
    end

    assign cnt_sat = &toggle_cnt;

    // Clear takes priority over a coincident pulse.
    always_ff @(posedge clk) begin
        if (rst || clr_cnt) begin
            toggle_cnt <= '0;
        end else if ((rise || fall) && !cnt_sat) begin
            toggle_cnt <= toggle_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_latch_q_sync_filter.sv
// Randomized + directed bench for latch_q_sync_filter against a run-length
// reference model; a second instance with CNT_W=3 exercises saturation.
module tb_latch_q_sync_filter;

    localparam int SYNC_STAGES = 2;
    localparam int FILT_CYCLES = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       q_in = 1'b0;
    logic       en = 1'b1;
    logic       clr_cnt = 1'b0;
    logic       q_sync, q_filt, rise, fall, cnt_sat;
    logic [7:0] toggle_cnt;
    logic       q_sync3, q_filt3, rise3, fall3, cnt_sat3;
    logic [2:0] toggle_cnt3;

    always #5 clk = ~clk;

    latch_q_sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_CYCLES(FILT_CYCLES), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .q_in(q_in), .en(en), .clr_cnt(clr_cnt),
        .q_sync(q_sync), .q_filt(q_filt), .rise(rise), .fall(fall),
        .toggle_cnt(toggle_cnt), .cnt_sat(cnt_sat)
    );

    latch_q_sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_CYCLES(FILT_CYCLES), .CNT_W(3)) u_dut3 (
        .clk(clk), .rst(rst), .q_in(q_in), .en(en), .clr_cnt(clr_cnt),
        .q_sync(q_sync3), .q_filt(q_filt3), .rise(rise3), .fall(fall3),
        .toggle_cnt(toggle_cnt3), .cnt_sat(cnt_sat3)
    );

    int checks = 0;
    int failures = 0;

    // Reference: history of sampled q_in, and a run length of cycles in which
    // the synchronized input has disagreed with the filtered level.
    logic hist[$];
    logic m_filt, m_rise, m_fall;
    int   m_run, m_cnt, m_cnt3;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        logic fin;
        if (rst) begin
            hist = {};
            repeat (SYNC_STAGES + 1) hist.push_back(1'b0);
            m_filt = 1'b0; m_rise = 1'b0; m_fall = 1'b0;
            m_run = 0; m_cnt = 0; m_cnt3 = 0;
            return;
        end
        fin = hist[SYNC_STAGES-1];
        hist.push_front(q_in);
        void'(hist.pop_back());
        if (clr_cnt) begin
            m_cnt = 0;
            m_cnt3 = 0;
        end else if (m_rise || m_fall) begin
            if (m_cnt < 255) m_cnt++;
            if (m_cnt3 < 7) m_cnt3++;
        end
        m_rise = 1'b0;
        m_fall = 1'b0;
        if (!en) begin
            m_run = 0;
        end else if (fin != m_filt) begin
            m_run++;
            if (m_run == FILT_CYCLES) begin
                m_filt = !m_filt;
                m_rise = m_filt;
                m_fall = !m_filt;
                m_run  = 0;
            end
        end else begin
            m_run = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("q_sync", q_sync, hist[SYNC_STAGES]);
        check("q_filt", q_filt, m_filt);
        check("rise", rise, m_rise);
        check("fall", fall, m_fall);
        check("toggle_cnt", toggle_cnt, m_cnt);
        check("cnt_sat", cnt_sat, m_cnt == 255);
        check("toggle_cnt3", toggle_cnt3, m_cnt3);
        check("cnt_sat3", cnt_sat3, m_cnt3 == 7);
        check("rise_fall_excl", rise & fall, 1'b0);
    endtask

    task automatic do_reset(input logic qv);
        rst = 1'b1; q_in = qv; en = 1'b1; clr_cnt = 1'b0;
        repeat (3) begin
            tick();
            check("rst_q_filt", q_filt, 1'b0);
            check("rst_cnt", toggle_cnt, 0);
        end
        rst = 1'b0;
    endtask

    logic lvl;
    int   hold;

    initial begin
        repeat (SYNC_STAGES + 1) hist.push_back(1'b0);
        m_filt = 1'b0; m_rise = 1'b0; m_fall = 1'b0;
        m_run = 0; m_cnt = 0; m_cnt3 = 0;

        // Reset with q_in high, then count edges from the first released edge.
        do_reset(1'b1);
        for (int k = 0; k <= 6; k++) begin
            tick();
            check("t1_q_sync", q_sync, k >= 2);
            check("t1_q_filt", q_filt, k >= 5);
            check("t1_rise", rise, k == 5);
            check("t1_cnt", toggle_cnt, k >= 6);
        end

        // Short high glitch is rejected.
        do_reset(1'b0);
        repeat (4) tick();
        q_in = 1'b1;
        repeat (3) tick();
        q_in = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            check("t2_q_filt", q_filt, 1'b0);
            check("t2_rise", rise, 1'b0);
        end
        check("t2_cnt", toggle_cnt, 0);

        // Clean toggles with 10 cycles per level; pulse lands on edge 5.
        lvl = 1'b0;
        for (int t = 0; t < 9; t++) begin
            lvl = !lvl;
            q_in = lvl;
            for (int k = 0; k < 10; k++) begin
                tick();
                check("t3_pulse", lvl ? rise : fall, k == 5);
                check("t3_q_filt", q_filt, (k >= 5) ? lvl : !lvl);
            end
            if (t == 4) check("t3_cnt5", toggle_cnt, 5);
        end
        check("t4_cnt9", toggle_cnt, 9);
        check("t4_cnt3_sat_val", toggle_cnt3, 7);
        check("t4_cnt3_sat", cnt_sat3, 1'b1);
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        check("t4_clr", toggle_cnt, 0);
        check("t4_clr3", toggle_cnt3, 0);
        check("t4_clr_sat3", cnt_sat3, 1'b0);

        // Clear coincident with a rise pulse.
        q_in = 1'b0;
        repeat (10) tick();
        q_in = 1'b1;
        for (int i = 0; i < 20 && !rise; i++) tick();
        check("t5_rise_seen", rise, 1'b1);
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        check("t5_cnt", toggle_cnt, 0);
        check("t5_q_filt", q_filt, 1'b1);
        tick();
        check("t5_cnt_hold", toggle_cnt, 0);

        // Disable during a pending rise, then re-enable.
        do_reset(1'b0);
        repeat (4) tick();
        q_in = 1'b1;
        repeat (4) tick();
        en = 1'b0;
        repeat (3) begin
            tick();
            check("t6_dis_q_filt", q_filt, 1'b0);
            check("t6_dis_rise", rise, 1'b0);
        end
        en = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            check("t6_rise", rise, k == FILT_CYCLES);
            check("t6_q_filt", q_filt, k >= FILT_CYCLES);
        end
        // Reset in the middle of a pending fall.
        q_in = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_rst_q_filt", q_filt, 1'b0);
        check("t6_rst_q_sync", q_sync, 1'b0);
        check("t6_rst_pulse", rise | fall, 1'b0);
        check("t6_rst_cnt", toggle_cnt, 0);

        // Drive the 8-bit counter into saturation.
        do_reset(1'b0);
        lvl = 1'b0;
        repeat (260) begin
            lvl = !lvl;
            q_in = lvl;
            repeat (6) tick();
        end
        check("sat_cnt", toggle_cnt, 255);
        check("sat_flag", cnt_sat, 1'b1);

        // Randomized traffic including glitches, enable drops, clears and resets.
        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                q_in = 1'($urandom_range(0, 1));
                hold = int'($urandom_range(1, 12));
            end
            hold--;
            en      = ($urandom_range(0, 99) >= 5);
            clr_cnt = ($urandom_range(0, 99) < 2);
            rst     = ($urandom_range(0, 999) < 3);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
